// File: rtl/maxmin_argsel_seq_pkg.sv
// Shared definitions for the sequential argmax/argmin engine.
package maxmin_argsel_seq_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned N_IN_DEF   = 4;

    // Index width for a set of n values; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/maxmin_argsel_seq_if.sv
// Sample-in / result-out handshake bundle for maxmin_argsel_seq.
interface maxmin_argsel_seq_if
    import maxmin_argsel_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_IN   = N_IN_DEF
);
    localparam int unsigned IDX_W = idx_w(N_IN);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] max_val;
    logic        [IDX_W-1:0]  max_idx;
    logic signed [DATA_W-1:0] min_val;
    logic        [IDX_W-1:0]  min_idx;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, max_val, max_idx, min_val, min_idx
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_val, max_idx, min_val, min_idx
    );

endinterface

// File: rtl/maxmin_update_cell.sv
// Combinational running max/min step; ties go to the newer sample.
module maxmin_update_cell #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 2
) (
    input  logic signed [DATA_W-1:0] i_cur_max,
    input  logic        [IDX_W-1:0]  i_cur_max_idx,
    input  logic signed [DATA_W-1:0] i_cur_min,
    input  logic        [IDX_W-1:0]  i_cur_min_idx,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic        [IDX_W-1:0]  i_idx,
    input  logic                     i_first,
    output logic signed [DATA_W-1:0] o_nxt_max,
    output logic        [IDX_W-1:0]  o_nxt_max_idx,
    output logic signed [DATA_W-1:0] o_nxt_min,
    output logic        [IDX_W-1:0]  o_nxt_min_idx
);

    // First sample seeds both extremes; later samples replace on >= / <=.
    always_comb begin
        o_nxt_max     = i_cur_max;
        o_nxt_max_idx = i_cur_max_idx;
        o_nxt_min     = i_cur_min;
        o_nxt_min_idx = i_cur_min_idx;
        if (i_first || (i_sample >= i_cur_max)) begin
            o_nxt_max     = i_sample;
            o_nxt_max_idx = i_idx;
        end
        if (i_first || (i_sample <= i_cur_min)) begin
            o_nxt_min     = i_sample;
            o_nxt_min_idx = i_idx;
        end
    end

endmodule

// File: rtl/maxmin_argsel_seq.sv
// Sequential argmax/argmin over a set of N_IN signed Q-values.
module maxmin_argsel_seq
    import maxmin_argsel_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_IN   = N_IN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    maxmin_argsel_seq_if.slave     bus
);

    localparam int unsigned          IDX_W    = idx_w(N_IN);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_IN - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         w_cnt_nxt;
    logic                     w_take;
    logic                     w_first;

    logic signed [DATA_W-1:0] r_max;
    logic signed [DATA_W-1:0] r_min;
    logic        [IDX_W-1:0]  r_max_idx;
    logic        [IDX_W-1:0]  r_min_idx;
    logic signed [DATA_W-1:0] w_max_nxt;
    logic signed [DATA_W-1:0] w_min_nxt;
    logic        [IDX_W-1:0]  w_max_idx_nxt;
    logic        [IDX_W-1:0]  w_min_idx_nxt;

    assign w_first = (r_cnt == '0);

    maxmin_update_cell #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cell (
        .i_cur_max     (r_max),
        .i_cur_max_idx (r_max_idx),
        .i_cur_min     (r_min),
        .i_cur_min_idx (r_min_idx),
        .i_sample      (bus.in_data),
        .i_idx         (r_cnt),
        .i_first       (w_first),
        .o_nxt_max     (w_max_nxt),
        .o_nxt_max_idx (w_max_idx_nxt),
        .o_nxt_min     (w_min_nxt),
        .o_nxt_min_idx (w_min_idx_nxt)
    );

    // Next-state and sample-take decode; flush outranks both handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (bus.flush) begin
                    w_cnt_nxt = '0;
                end else if (bus.in_valid) begin
                    w_take = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.out_ready) begin
                    w_state_nxt = ST_ACCEPT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and sample counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Result registers advance only on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max     <= '0;
            r_max_idx <= '0;
            r_min     <= '0;
            r_min_idx <= '0;
        end else if (w_take) begin
            r_max     <= w_max_nxt;
            r_max_idx <= w_max_idx_nxt;
            r_min     <= w_min_nxt;
            r_min_idx <= w_min_idx_nxt;
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCEPT);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.max_val   = r_max;
    assign bus.max_idx   = r_max_idx;
    assign bus.min_val   = r_min;
    assign bus.min_idx   = r_min_idx;

endmodule

// File: tb/tb_maxmin_argsel_seq.sv
// Randomized and directed bench for maxmin_argsel_seq against a set-level model.
module tb_maxmin_argsel_seq;

    localparam int N       = 4;
    localparam int INT_MIN = int'(32'h8000_0000);
    localparam int INT_MAX = int'(32'h7FFF_FFFF);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    maxmin_argsel_seq_if #(.DATA_W(32), .N_IN(N)) bus_if ();

    maxmin_argsel_seq #(.DATA_W(32), .N_IN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Set-level model: collects accepted samples, evaluates the whole set at once.
    bit m_started = 1'b0;
    bit m_pending = 1'b0;
    bit m_zero    = 1'b1;
    int m_q[$];
    int e_max = 0, e_maxi = 0, e_min = 0, e_mini = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0;
            m_pending = 1'b0;
            m_zero    = 1'b1;
            m_q.delete();
            e_max = 0; e_maxi = 0; e_min = 0; e_mini = 0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (bus_if.flush) begin
            m_q.delete();
            m_pending = 1'b0;
        end else if (m_pending) begin
            if (bus_if.out_ready) m_pending = 1'b0;
        end else if (bus_if.in_valid) begin
            m_q.push_back(int'(bus_if.in_data));
            m_zero = 1'b0;
            if (m_q.size() == N) begin
                e_max = m_q[0];
                e_min = m_q[0];
                foreach (m_q[i]) begin
                    if (m_q[i] > e_max) e_max = m_q[i];
                    if (m_q[i] < e_min) e_min = m_q[i];
                end
                foreach (m_q[i]) begin
                    if (m_q[i] == e_max) e_maxi = i;
                    if (m_q[i] == e_min) e_mini = i;
                end
                m_q.delete();
                m_pending = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", longint'(bus_if.in_ready), longint'(m_started && !m_pending));
        chk("out_valid", longint'(bus_if.out_valid), longint'(m_pending));
        if (m_pending || m_zero) begin
            chk("max_val", longint'($signed(bus_if.max_val)), longint'(e_max));
            chk("max_idx", longint'(bus_if.max_idx), longint'(e_maxi));
            chk("min_val", longint'($signed(bus_if.min_val)), longint'(e_min));
            chk("min_idx", longint'(bus_if.min_idx), longint'(e_mini));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int v, input int gap_max);
        int g;
        bit acc;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            bus_if.in_valid = 1'b0;
            bus_if.in_data  = $urandom;
            step();
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = v;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus_if.in_ready;
            step();
            n++;
        end
        bus_if.in_valid = 1'b0;
        if (!acc) chk("beat_timeout", 0, 1);
    endtask

    task automatic send_set(input int v0, input int v1, input int v2, input int v3, input int gap);
        send_beat(v0, gap);
        send_beat(v1, gap);
        send_beat(v2, gap);
        send_beat(v3, gap);
        chk("latency_out_valid", longint'(bus_if.out_valid), 1);
    endtask

    task automatic take_result(input int hold, input bit lit, input string tag,
                               input int xmax, input int xmaxi, input int xmin, input int xmini);
        int n;
        n = 0;
        while (!bus_if.out_valid && n < 50) begin
            step();
            n++;
        end
        if (!bus_if.out_valid) chk({tag, "_result_timeout"}, 0, 1);
        if (lit) begin
            chk({tag, "_max_val"}, longint'($signed(bus_if.max_val)), longint'(xmax));
            chk({tag, "_max_idx"}, longint'(bus_if.max_idx), longint'(xmaxi));
            chk({tag, "_min_val"}, longint'($signed(bus_if.min_val)), longint'(xmin));
            chk({tag, "_min_idx"}, longint'(bus_if.min_idx), longint'(xmini));
        end
        // Offer input throughout the hold and the handshake cycle; none may be taken.
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = $urandom;
        repeat (hold) step();
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        chk({tag, "_after_handshake"}, longint'(bus_if.out_valid), 0);
    endtask

    function automatic int rand_val();
        case ($urandom % 6)
            0:       return INT_MIN;
            1:       return INT_MAX;
            2:       return int'($urandom_range(0, 6)) - 3;
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        bus_if.flush     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_max_val", longint'($signed(bus_if.max_val)), 0);
        chk("reset_min_idx", longint'(bus_if.min_idx), 0);
        chk("reset_out_valid", longint'(bus_if.out_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", longint'(bus_if.in_ready), 0);
        step();
        chk("accept_in_ready", longint'(bus_if.in_ready), 1);

        send_set(5, -3, 12, 7, 0);
        take_result(0, 1, "t1", 12, 2, -3, 1);

        send_set(4, 4, -1, -1, 0);
        take_result(0, 1, "t2_ties", 4, 1, -1, 3);

        send_set(INT_MIN, INT_MAX, 0, -1, 0);
        take_result(0, 1, "t3_extremes", INT_MAX, 1, INT_MIN, 0);

        send_set(10, 20, 30, 40, 0);
        take_result(5, 1, "t4_hold", 40, 3, 10, 0);
        send_set(1, 2, 3, 4, 0);
        take_result(0, 1, "t4_next", 4, 3, 1, 0);

        send_set(9, 8, 7, 6, 3);
        take_result(0, 1, "t5_gaps", 9, 0, 6, 3);

        // Flush mid-set with a simultaneous input beat offered.
        send_beat(11, 0);
        send_beat(-5, 0);
        bus_if.flush    = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 99;
        step();
        bus_if.flush    = 1'b0;
        bus_if.in_valid = 1'b0;
        send_set(0, 0, 0, 0, 0);
        take_result(0, 1, "t6_flush", 0, 3, 0, 3);

        // Flush while a result is pending, together with out_ready.
        send_set(1, 1, 1, 1, 0);
        bus_if.flush     = 1'b1;
        bus_if.out_ready = 1'b1;
        step();
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        chk("flush_done_out_valid", longint'(bus_if.out_valid), 0);
        send_set(-7, 3, -7, 3, 0);
        take_result(0, 1, "t6_after", 3, 3, -7, 2);

        for (int s = 0; s < 40; s++) begin
            if ($urandom % 8 == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_beat(rand_val(), 1);
                bus_if.flush = 1'b1;
                step();
                bus_if.flush = 1'b0;
            end
            send_set(rand_val(), rand_val(), rand_val(), rand_val(), int'($urandom % 3));
            take_result(int'($urandom % 4), 0, "rnd", 0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of a set.
        send_beat(17, 0);
        send_beat(-17, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_max_val", longint'($signed(bus_if.max_val)), 0);
        chk("arst_min_val", longint'($signed(bus_if.min_val)), 0);
        chk("arst_in_ready", longint'(bus_if.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_release_in_ready", longint'(bus_if.in_ready), 0);
        step();
        chk("arst_next_in_ready", longint'(bus_if.in_ready), 1);
        send_set(5, -3, 12, 7, 0);
        take_result(0, 1, "post_reset", 12, 2, -3, 1);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
